imm_encoder: RTL

//  Inverse of the decode-side immediate extender: packs an immediate plus register/opcode fields into a
//  32-bit RV32I instruction word for I/S/B/J/U formats. Range and alignment checks run per request.
//  2-stage valid/ready pipeline with saturating statistics counters; used by the test-program generator
//  and the instruction-memory loader.

---
 rtl/imm_encoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs imm + rd/rs1/rs2/funct3/opcode into an I/S/B/J/U word.
// Two-stage valid/ready pipeline (range/alignment check, then pack) with saturating transfer counters.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_out,
  output logic [1:0]       err_code,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0]  SRC_I = 3'd0;
  localparam logic [2:0]  SRC_S = 3'd1;
  localparam logic [2:0]  SRC_B = 3'd2;
  localparam logic [2:0]  SRC_J = 3'd3;
  localparam logic [2:0]  SRC_U = 3'd4;
  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_RANGE   = 2'b01;
  localparam logic [1:0]  ERR_ALIGN   = 2'b10;
  localparam logic [1:0]  ERR_ILLEGAL = 2'b11;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } req_t;

  logic             s1_valid_q, s1_valid_d;
  req_t             s1_req_q, s1_req_d;
  logic [1:0]       s1_err_q, s1_err_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             s1_adv, s2_adv, xfer;
  logic [1:0]       chk_err;
  logic [31:0]      packed_word;
  logic signed [31:0] imm_s;

  // Handshake: a beat moves when valid && ready in the same cycle; a stage advances when it is
  // empty or its downstream takes the current word, so a stalled output holds its data stable.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign xfer     = out_valid_q && out_ready;
  assign imm_s    = imm;

  // Illegal source beats misalignment, which beats an out-of-range value.
  always_comb begin
    chk_err = ERR_OK;
    case (imm_src)
      SRC_I, SRC_S: if (imm_s < -32'sd2048 || imm_s > 32'sd2047) chk_err = ERR_RANGE;
      SRC_B: begin
        if (imm[0]) chk_err = ERR_ALIGN;
        else if (imm_s < -32'sd4096 || imm_s > 32'sd4094) chk_err = ERR_RANGE;
      end
      SRC_J: begin
        if (imm[0]) chk_err = ERR_ALIGN;
        else if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) chk_err = ERR_RANGE;
      end
      SRC_U: if (imm[11:0] != 12'd0) chk_err = ERR_ALIGN;
      default: chk_err = ERR_ILLEGAL;
    endcase
  end

  always_comb begin
    packed_word = NOP_WORD;
    if (s1_err_q == ERR_OK) begin
      case (s1_req_q.src)
        SRC_I: packed_word = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.rd, s1_req_q.opcode};
        SRC_S: packed_word = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.imm[4:0], s1_req_q.opcode};
        SRC_B: packed_word = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2, s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.imm[4:1], s1_req_q.imm[11],
                              s1_req_q.opcode};
        SRC_J: packed_word = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                              s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
        SRC_U: packed_word = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
        default: packed_word = NOP_WORD;
      endcase
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_req_d.src    = imm_src;
        s1_req_d.imm    = imm;
        s1_req_d.opcode = opcode;
        s1_req_d.rd     = rd;
        s1_req_d.rs1    = rs1;
        s1_req_d.rs2    = rs2;
        s1_req_d.funct3 = funct3;
        s1_err_d        = chk_err;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        inst_d = packed_word;
        err_d  = s1_err_q;
      end
    end
  end

  // Clear takes precedence over a transfer in the same cycle.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      enc_cnt_d = '0;
      err_cnt_d = '0;
    end else if (xfer) begin
      if (err_q == ERR_OK) begin
        if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_ONE;
      end else begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_err_q    <= ERR_OK;
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= ERR_OK;
      enc_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      enc_cnt_q   <= enc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign inst_out  = inst_q;
  assign err_code  = err_q;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

endmodule
